syncfifo: RTL

//  Single-clock FIFO; parametrised successor to the asyncfifo for same-domain buffering (fetch queue, store buffer, bus response queues).

---
 rtl/syncfifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/syncfifo.sv
// Single-clock FIFO with FWFT/registered read, occupancy, thresholds,
// flush and sticky error flags.
// Ports: clk, rst (sync, active-high), flush; write side wpush/wdata/wfull;
// read side rpull/rdata/rvalid/rempty; status count, almost_full,
// almost_empty, overflow, underflow.
module syncfifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b1,
  parameter int AFULL_TH   = 14,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wpush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  input  logic                  rpull,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AFULL =
    (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY =
    (ADDR_WIDTH+1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_wfull;
  logic                  r_rempty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [ADDR_WIDTH:0]   w_count_n;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ADDR_WIDTH-1:0] w_raddr;

  // Accept decisions use only the registered flags, so a full FIFO
  // cannot take a push even when a pop frees a slot in the same cycle.
  always_comb begin
    w_push_ok = wpush & ~r_wfull;
    w_pop_ok  = rpull & ~r_rempty;
    w_count_n = r_count
              + (ADDR_WIDTH+1)'(w_push_ok)
              - (ADDR_WIDTH+1)'(w_pop_ok);
    w_waddr   = r_wptr[ADDR_WIDTH-1:0];
    w_raddr   = r_rptr[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (flush) begin
      // Error flags survive a flush; only rst clears them.
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      r_count  <= w_count_n;
      r_wfull  <= (w_count_n == LP_DEPTH);
      r_rempty <= (w_count_n == '0);
      r_afull  <= (w_count_n >= LP_AFULL);
      r_aempty <= (w_count_n <= LP_AEMPTY);
      r_ovf    <= r_ovf | (wpush & r_wfull);
      r_unf    <= r_unf | (rpull & r_rempty);
    end
  end

  // Storage has no reset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push_ok)
      r_mem[w_waddr] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata  = r_mem[w_raddr];
      assign rvalid = ~r_rempty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_rdata;
      logic                  r_rvalid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else if (flush) begin
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_pop_ok;
          if (w_pop_ok) r_rdata <= r_mem[w_raddr];
        end
      end

      assign rdata  = r_rdata;
      assign rvalid = r_rvalid;
    end
  endgenerate

  assign wfull        = r_wfull;
  assign rempty       = r_rempty;
  assign count        = r_count;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule
